mmc3_scanline_irq: RTL
======================

MMC3_SCANLINE_IRQ -- requirements
Module: mmc3_scanline_irq

Interface
REQ-001 SHALL have parameter A12_LOW_CYCLES, default 3: number of consecutive clock samples with A12 low needed before an A12 rise counts.
REQ-002 SHALL have parameter MMC3_REV_A, default 0: 1 selects the old-revision zero-reload rule.
REQ-003 SHALL have port m2  input  1  sole clock; all state updates on falling edge of m2.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port romsel  input  1  CPU /ROMSEL, low means $8000-$FFFF access.
REQ-006 SHALL have port cpu_rw_in  input  1  CPU R/W, 0 means write.
REQ-007 SHALL have port cpu_addr_in  input  15  CPU A14..A0.
REQ-008 SHALL have port cpu_data_in  input  8  CPU data bus, sampled only.
REQ-009 SHALL have port ppu_a12  input  1  PPU address bit 12.
REQ-010 SHALL have port mapper_active  input  1  1 when the MMC3-family mapper is selected; 0 ignores register writes and A12.
REQ-011 SHALL have port irq  output  1  CPU /IRQ, active-low.
REQ-012 SHALL have port irq_counter  output  8  current counter value, for debug and readback.

Function
REQ-013 Register write SHALL mean a falling edge of m2 with romsel=0, cpu_rw_in=0 and mapper_active=1; only cpu_addr_in[14:13] and cpu_addr_in[0] are decoded.
REQ-014 Write to $C000 (even) SHALL set latch to cpu_data_in.
REQ-015 Write to $C001 (odd) SHALL clear the counter to 0 and set reload_flag.
REQ-016 Write to $E000 (even) SHALL clear enable and clear irq_pending.
REQ-017 Write to $E001 (odd) SHALL set enable and leave irq_pending unchanged.
REQ-018 Writes to $8000-$BFFF SHALL be ignored.
REQ-019 A12 filter: low_cnt SHALL increment, saturating at A12_LOW_CYCLES, on each edge sampling ppu_a12=0.
REQ-020 A12 filter: low_cnt SHALL clear on each edge sampling ppu_a12=1.
REQ-021 A counter clock SHALL occur on an edge sampling ppu_a12=1 when low_cnt==A12_LOW_CYCLES and mapper_active=1; at most one clock per A12 high period.
REQ-022 On a counter clock with counter==0 or reload_flag=1, the counter SHALL load latch and reload_flag SHALL clear.
REQ-023 On any other counter clock, the counter SHALL decrement by 1; 8-bit, no wrap possible.
REQ-024 After a counter clock, if the new counter value is 0 and enable=1, irq_pending SHALL set; with MMC3_REV_A=1, only if the old counter was nonzero or reload_flag was set.
REQ-025 irq SHALL equal ~irq_pending, registered, with no combinational path from inputs.
REQ-026 Latency: irq SHALL go low on the same m2 falling edge as the counter clock that triggers it.
REQ-027 Write to $C000 on the same edge as a counter clock: the reload SHALL use the old latch value.
REQ-028 Write to $C001 on the same edge as a counter clock: the reload SHALL take priority and the counter loads latch.
REQ-029 Write to $E000 on the same edge as an IRQ-triggering clock: the disable SHALL win and irq stays high.
REQ-030 Write to $E001 on the same edge as an IRQ-triggering clock: the IRQ SHALL assert.
REQ-031 mapper_active=0 SHALL freeze the counter, latch and flags and force irq high; the filter keeps tracking A12.
REQ-032 latch=0 with enable=1 SHALL produce an IRQ on every counter clock (REV_A=0).
REQ-033 irq_counter SHALL expose the counter register directly.

Reset
REQ-034 While reset_n=0 at an m2 falling edge: counter, latch, reload_flag, enable and irq_pending SHALL all be 0 and low_cnt SHALL be 0.
REQ-035 During reset, irq SHALL be 1 and irq_counter SHALL be 0x00.
REQ-036 Reset asserted mid-count SHALL discard all state on that edge; register writes during reset SHALL be ignored.
REQ-037 After reset release, the first A12 rise SHALL count only after A12_LOW_CYCLES low samples.

Verification
REQ-038 Basic count: write $C000=0x03, $C001, $E001, then 4 filtered A12 rises -> counter 3,2,1,0; irq low after the 4th rise.
REQ-039 Acknowledge: with irq low, write $E000 -> irq high on that edge, counter unchanged at 0.
REQ-040 Filter: A12 pulses separated by only 2 low samples after one valid rise -> no further clocks; counter unchanged.
REQ-041 Zero-latch rule: latch=0 with enable set, 2 rises -> irq low with REV_A=0; irq stays high with REV_A=1 until a $C001 write.
REQ-042 Simultaneous write: $E000 on the same edge as the triggering rise -> irq stays high.
REQ-043 Simultaneous write: $C000=0x10 on the reload edge -> counter loads the old latch value.
REQ-044 Reset mid-count: reset_n low for 1 edge at counter=0x05 -> counter 0x00, irq high, enable 0.

Source files
------------

// File: rtl/mmc3_scanline_irq.sv
// MMC3 scanline IRQ counter: PPU A12 rise filter, reloadable 8-bit down-counter, CPU register decode.
// Latency: all state changes on the m2 falling edge that samples the cause; irq is registered and moves on that same edge.
// Backpressure: none; CPU writes and A12 edges are accepted every m2 cycle.
//
// Ports:
//   m2            sole clock, state updates on its falling edge
//   reset_n       synchronous active-low reset
//   romsel        CPU /ROMSEL (low = $8000-$FFFF)
//   cpu_rw_in     CPU R/W (0 = write)
//   cpu_addr_in   CPU A14..A0 (only [14:13] and [0] decoded)
//   cpu_data_in   CPU data bus
//   ppu_a12       PPU address bit 12
//   mapper_active 1 = this mapper selected; 0 freezes counter state and forces irq high
//   irq           CPU /IRQ, active-low, registered
//   irq_counter   current counter value
module mmc3_scanline_irq #(
  parameter int A12_LOW_CYCLES = 3,
  parameter int MMC3_REV_A     = 0
) (
  input  logic        m2,
  input  logic        reset_n,
  input  logic        romsel,
  input  logic        cpu_rw_in,
  input  logic [14:0] cpu_addr_in,
  input  logic [7:0]  cpu_data_in,
  input  logic        ppu_a12,
  input  logic        mapper_active,
  output logic        irq,
  output logic [7:0]  irq_counter
);

  localparam int LW = (A12_LOW_CYCLES < 1) ? 1 : $clog2(A12_LOW_CYCLES + 1);
  localparam logic [LW-1:0] LOW_MAX = LW'(A12_LOW_CYCLES);

  logic [7:0]    counter_q, counter_d;
  logic [7:0]    latch_q, latch_d;
  logic [LW-1:0] low_cnt_q, low_cnt_d;
  logic          reload_q, reload_d;
  logic          enable_q, enable_d;
  logic          pending_q, pending_d;
  logic          irq_q, irq_d;

  logic reg_wr, wr_c000, wr_c001, wr_e000, wr_e001;
  logic ctr_clk, reload_now, irq_set;
  logic unused_addr;

  assign unused_addr = ^cpu_addr_in[12:1];

  assign reg_wr  = ~romsel & ~cpu_rw_in & mapper_active;
  assign wr_c000 = reg_wr && (cpu_addr_in[14:13] == 2'b10) && !cpu_addr_in[0];
  assign wr_c001 = reg_wr && (cpu_addr_in[14:13] == 2'b10) &&  cpu_addr_in[0];
  assign wr_e000 = reg_wr && (cpu_addr_in[14:13] == 2'b11) && !cpu_addr_in[0];
  assign wr_e001 = reg_wr && (cpu_addr_in[14:13] == 2'b11) &&  cpu_addr_in[0];

  // low_cnt clears on every high sample, so only the first high sample of a
  // high period can see it saturated: one clock per A12 high period.
  assign ctr_clk = ppu_a12 && (low_cnt_q == LOW_MAX) && mapper_active;

  // A $C001 write on the clocking edge counts as a pending reload.
  assign reload_now = (counter_q == 8'd0) || reload_q || wr_c001;

  always_comb begin
    low_cnt_d = low_cnt_q;
    if (ppu_a12) begin
      low_cnt_d = '0;
    end else if (low_cnt_q != LOW_MAX) begin
      low_cnt_d = low_cnt_q + 1'b1;
    end

    // Reload on the same edge still uses latch_q (the old value).
    latch_d = wr_c000 ? cpu_data_in : latch_q;

    enable_d = enable_q;
    if (wr_e000) begin
      enable_d = 1'b0;
    end else if (wr_e001) begin
      enable_d = 1'b1;
    end

    counter_d = counter_q;
    reload_d  = reload_q;
    irq_set   = 1'b0;
    if (ctr_clk) begin
      if (reload_now) begin
        counter_d = latch_q;
        reload_d  = 1'b0;
      end else begin
        counter_d = counter_q - 8'd1;
      end
      // enable_d lets a same-edge $E000 suppress and a same-edge $E001 allow the IRQ.
      irq_set = (counter_d == 8'd0) && enable_d &&
                ((MMC3_REV_A == 0) || (counter_q != 8'd0) || reload_q || wr_c001);
    end else if (wr_c001) begin
      counter_d = 8'd0;
      reload_d  = 1'b1;
    end

    pending_d = pending_q;
    if (wr_e000) begin
      pending_d = 1'b0;
    end else if (irq_set) begin
      pending_d = 1'b1;
    end

    irq_d = ~(pending_d & mapper_active);
  end

  always_ff @(negedge m2) begin
    if (!reset_n) begin
      counter_q <= 8'd0;
      latch_q   <= 8'd0;
      low_cnt_q <= '0;
      reload_q  <= 1'b0;
      enable_q  <= 1'b0;
      pending_q <= 1'b0;
      irq_q     <= 1'b1;
    end else begin
      counter_q <= counter_d;
      latch_q   <= latch_d;
      low_cnt_q <= low_cnt_d;
      reload_q  <= reload_d;
      enable_q  <= enable_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
    end
  end

  assign irq         = irq_q;
  assign irq_counter = counter_q;

endmodule
